// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: turns M-stage load/store controls into a byte-lane
// req/ready memory access, stalls the pipeline while it runs, and formats load data.
`timescale 1ns/1ps
module mem_access_unit #(
   parameter int XLEN     = 32,
   parameter int MAX_WAIT = 15
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            MemReadM,
   input  logic            MemWriteM,
   input  logic [2:0]      funct3M,
   input  logic [XLEN-1:0] ALUResultM,
   input  logic [XLEN-1:0] WriteDataM,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [3:0]      mem_be,
   output logic [XLEN-1:0] mem_wdata,
   input  logic [XLEN-1:0] mem_rdata,
   input  logic            mem_ready,
   output logic [XLEN-1:0] ReadDataM,
   output logic            StallM,
   output logic            ErrM
);

   localparam int CW = $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

   typedef enum logic [1:0] {CLEAR, IDLE, BUSY, DONE} state_t;

   state_t            state_q, state_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
   logic [3:0]        mem_be_q, mem_be_d;
   logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
   logic [XLEN-1:0]   read_data_q, read_data_d;
   logic              err_q, err_d;
   logic [CW-1:0]     wait_cnt_q, wait_cnt_d;
   logic [2:0]        f3_q, f3_d;
   logic [1:0]        off_q, off_d;

   logic              access;
   logic              f3_legal;
   logic              misaligned;
   logic              ok_access;
   logic [3:0]        be_new;
   logic [XLEN-1:0]   wdata_new;
   logic [7:0]        byte_sel;
   logic [15:0]       half_sel;
   logic [XLEN-1:0]   load_fmt;

   assign access = MemReadM | MemWriteM;

   // A simultaneous read+write is treated as a store, so legality follows the store table.
   always_comb begin
      if (MemWriteM) begin
         f3_legal = (funct3M[2] == 1'b0) && (funct3M[1:0] != 2'b11);
      end else begin
         f3_legal = (funct3M != 3'b011) && (funct3M != 3'b110) && (funct3M != 3'b111);
      end
   end

   assign misaligned = ((funct3M[1:0] == 2'b01) && ALUResultM[0]) ||
                       ((funct3M[1:0] == 2'b10) && (ALUResultM[1:0] != 2'b00));
   assign ok_access  = access && f3_legal && !misaligned;

   always_comb begin
      be_new    = 4'b1111;
      wdata_new = WriteDataM;
      case (funct3M[1:0])
         2'b00: begin
            if (MemWriteM) be_new = 4'b0001 << ALUResultM[1:0];
            wdata_new = {4{WriteDataM[7:0]}};
         end
         2'b01: begin
            if (MemWriteM) be_new = 4'b0011 << ALUResultM[1:0];
            wdata_new = {2{WriteDataM[15:0]}};
         end
         default: ;
      endcase
   end

   assign byte_sel = mem_rdata[{off_q, 3'b000} +: 8];
   assign half_sel = mem_rdata[{off_q[1], 4'b0000} +: 16];

   always_comb begin
      case (f3_q)
         3'b000:  load_fmt = {{(XLEN-8){byte_sel[7]}}, byte_sel};
         3'b001:  load_fmt = {{(XLEN-16){half_sel[15]}}, half_sel};
         3'b100:  load_fmt = {{(XLEN-8){1'b0}}, byte_sel};
         3'b101:  load_fmt = {{(XLEN-16){1'b0}}, half_sel};
         default: load_fmt = mem_rdata;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_be_d    = mem_be_q;
      mem_wdata_d = mem_wdata_q;
      read_data_d = read_data_q;
      err_d       = 1'b0;
      wait_cnt_d  = wait_cnt_q;
      f3_d        = f3_q;
      off_d       = off_q;
      StallM      = 1'b0;
      case (state_q)
         CLEAR: state_d = IDLE;
         IDLE: begin
            if (ok_access) begin
               StallM      = 1'b1;
               mem_req_d   = 1'b1;
               mem_we_d    = MemWriteM;
               mem_addr_d  = {ALUResultM[XLEN-1:2], 2'b00};
               mem_be_d    = be_new;
               mem_wdata_d = wdata_new;
               f3_d        = funct3M;
               off_d       = ALUResultM[1:0];
               wait_cnt_d  = '0;
               state_d     = BUSY;
            end else if (access) begin
               err_d = 1'b1;
            end
         end
         BUSY: begin
            StallM = 1'b1;
            if (mem_ready) begin
               mem_req_d = 1'b0;
               if (!mem_we_q) read_data_d = load_fmt;
               state_d = DONE;
            end else begin
               wait_cnt_d = wait_cnt_q + CW'(1);
               if (wait_cnt_q == WAIT_LAST) begin
                  mem_req_d = 1'b0;
                  err_d     = 1'b1;
                  state_d   = DONE;
               end
            end
         end
         DONE: begin
            wait_cnt_d = '0;
            state_d    = IDLE;
         end
         default: state_d = CLEAR;
      endcase
   end

   // Falling-edge update keeps this unit in step with the pipeline registers.
   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= CLEAR;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_be_q    <= 4'b0000;
         mem_wdata_q <= '0;
         read_data_q <= '0;
         err_q       <= 1'b0;
         wait_cnt_q  <= '0;
         f3_q        <= 3'b000;
         off_q       <= 2'b00;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_be_q    <= mem_be_d;
         mem_wdata_q <= mem_wdata_d;
         read_data_q <= read_data_d;
         err_q       <= err_d;
         wait_cnt_q  <= wait_cnt_d;
         f3_q        <= f3_d;
         off_q       <= off_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_be    = mem_be_q;
   assign mem_wdata = mem_wdata_q;
   assign ReadDataM = read_data_q;
   assign ErrM      = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus random loads/stores
// compared against an arithmetic reference model of the access rules.
`timescale 1ns/1ps
module tb_mem_access_unit;

   localparam int MAX_WAIT = 15;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemReadM, MemWriteM;
   logic [2:0]  funct3M;
   logic [31:0] ALUResultM, WriteDataM;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata, mem_rdata;
   logic        mem_ready;
   logic [31:0] ReadDataM;
   logic        StallM, ErrM;

   int errors = 0;
   int checks = 0;
   int txn    = 0;
   logic [31:0] exp_rd = 32'h0;

   mem_access_unit #(.XLEN(32), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .reset(reset),
      .MemReadM(MemReadM), .MemWriteM(MemWriteM), .funct3M(funct3M),
      .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .ReadDataM(ReadDataM), .StallM(StallM), .ErrM(ErrM)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=running required=finished");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // The DUT updates on the falling edge; inputs change and outputs are sampled just after it.
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   function automatic bit model_legal(input bit st, input logic [2:0] f3, input logic [31:0] a);
      int size;
      bit ok;
      if (st) ok = (f3 <= 3'd2);
      else    ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
      size = 1 << (int'(f3) % 4);
      return ok && ((a % size) == 0);
   endfunction

   function automatic logic [31:0] model_be(input bit st, input logic [2:0] f3, input logic [1:0] off);
      if (!st)          return 32'd15;
      if (f3 == 3'd0)   return 32'd1 << off;
      if (f3 == 3'd1)   return 32'd3 << off;
      return 32'd15;
   endfunction

   function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
      if (f3 == 3'd0) return (wd & 32'hFF) * 32'h01010101;
      if (f3 == 3'd1) return (wd & 32'hFFFF) * 32'h00010001;
      return wd;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] rd);
      logic [31:0] b, h;
      b = (rd >> (8 * int'(off))) & 32'hFF;
      h = (rd >> (16 * (int'(off) / 2))) & 32'hFFFF;
      case (f3)
         3'd0:    return (b >= 32'd128)   ? b + 32'hFFFFFF00 : b;
         3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF0000 : h;
         3'd4:    return b;
         3'd5:    return h;
         default: return rd;
      endcase
   endfunction

   task automatic idle_inputs();
      MemReadM  = 1'b0;
      MemWriteM = 1'b0;
   endtask

   // Runs one M-stage instruction from IDLE to the following IDLE; w = ready-wait cycles.
   task automatic do_access(input bit rd, input bit wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rdv, input int w);
      bit st;
      bit legal;
      logic [31:0] prev_rd;
      st = wr;
      legal = model_legal(st, f3, addr);
      prev_rd = exp_rd;
      MemReadM = rd; MemWriteM = wr; funct3M = f3; ALUResultM = addr; WriteDataM = wd;
      mem_ready = 1'b0; mem_rdata = $urandom;
      #1;
      if (!legal) begin
         chk("err_stall", StallM, 0);
         tick();
         idle_inputs();
         #1;
         chk("err_flag", ErrM, 1);
         chk("err_noreq", mem_req, 0);
         chk("err_rdata_held", ReadDataM, exp_rd);
         chk("err_stall_after", StallM, 0);
         tick();
         chk("err_oneshot", ErrM, 0);
         $display("txn %0d: %s f3=%0d addr=%h -> error", txn, st ? "store" : "load", f3, addr);
         txn++;
         return;
      end
      chk("idle_stall", StallM, 1);
      chk("idle_noreq", mem_req, 0);
      tick();
      chk("req", mem_req, 1);
      chk("req_we", mem_we, st);
      chk("req_addr", mem_addr, addr & 32'hFFFFFFFC);
      chk("req_be", mem_be, model_be(st, f3, addr[1:0]));
      if (st) chk("req_wdata", mem_wdata, model_wdata(f3, wd));
      chk("busy_stall", StallM, 1);
      chk("busy_noerr", ErrM, 0);
      if (w < MAX_WAIT) begin
         repeat (w) begin
            tick();
            chk("wait_req", mem_req, 1);
            chk("wait_stall", StallM, 1);
            chk("wait_noerr", ErrM, 0);
         end
         mem_ready = 1'b1; mem_rdata = rdv;
         tick();
         mem_ready = 1'b0; mem_rdata = $urandom;
         idle_inputs();
         #1;
         if (!st) exp_rd = model_load(f3, addr[1:0], rdv);
         chk("done_noreq", mem_req, 0);
         chk("done_stall", StallM, 0);
         chk("done_noerr", ErrM, 0);
         chk("done_rdata", ReadDataM, exp_rd);
      end else begin
         repeat (MAX_WAIT - 1) begin
            tick();
            chk("tmo_wait_req", mem_req, 1);
            chk("tmo_wait_stall", StallM, 1);
         end
         tick();
         idle_inputs();
         #1;
         chk("tmo_noreq", mem_req, 0);
         chk("tmo_err", ErrM, 1);
         chk("tmo_stall", StallM, 0);
         chk("tmo_rdata_held", ReadDataM, prev_rd);
         mem_ready = 1'b1; mem_rdata = rdv;
      end
      tick();
      mem_ready = 1'b0;
      #1;
      chk("back_idle_noerr", ErrM, 0);
      chk("back_idle_noreq", mem_req, 0);
      chk("back_idle_rdata", ReadDataM, exp_rd);
      $display("txn %0d: %s f3=%0d addr=%h wait=%0d rdata_out=%h", txn,
               st ? "store" : "load", f3, addr, w, ReadDataM);
      txn++;
   endtask

   initial begin
      reset = 1'b0;
      MemReadM = 1'b1; MemWriteM = 1'b0; funct3M = 3'b010;
      ALUResultM = 32'h0000_0100; WriteDataM = 32'hFFFF_FFFF;
      mem_rdata = 32'hFFFF_FFFF; mem_ready = 1'b1;

      // Reset held across several clocks with an access pending.
      tick(); tick();
      chk("rst_req", mem_req, 0);
      chk("rst_we", mem_we, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_be", mem_be, 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_rdata", ReadDataM, 0);
      chk("rst_err", ErrM, 0);
      chk("rst_stall", StallM, 0);
      mem_ready = 1'b0;
      reset = 1'b1;
      #1;
      chk("clear_stall", StallM, 0);
      tick();
      chk("clear_noreq", mem_req, 0);
      do_access(1, 0, 3'b010, 32'h0000_0100, 32'h0, 32'h1357_9BDF, 0);

      // LB sign-extended, SH lane-replicated with waits, misaligned LW, LHU zero-extended.
      do_access(1, 0, 3'b000, 32'h0000_1003, 32'h0, 32'h80AA_5511, 0);
      chk("lb_literal", ReadDataM, 32'hFFFF_FF80);
      do_access(0, 1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'h0, 3);
      chk("sh_rdata_literal", ReadDataM, 32'hFFFF_FF80);
      do_access(1, 0, 3'b010, 32'h0000_3001, 32'h0, 32'h0, 0);
      do_access(1, 0, 3'b101, 32'h0000_3002, 32'h0, 32'hBEEF_0000, 1);
      chk("lhu_literal", ReadDataM, 32'h0000_BEEF);

      // Ready never arrives: timeout, then a late ready in DONE is ignored.
      do_access(1, 0, 3'b000, 32'h0000_4001, 32'h0, 32'h0000_7700, MAX_WAIT);

      // Reset while BUSY drops the request immediately and forces CLEAR again.
      MemReadM = 1'b1; MemWriteM = 1'b0; funct3M = 3'b010; ALUResultM = 32'h0000_5000;
      #1;
      tick();
      chk("pre_rst_req", mem_req, 1);
      reset = 1'b0;
      #1;
      exp_rd = 32'h0;
      chk("midrst_req", mem_req, 0);
      chk("midrst_rdata", ReadDataM, 0);
      chk("midrst_stall", StallM, 0);
      mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      tick();
      mem_ready = 1'b0;
      reset = 1'b1;
      #1;
      chk("reclear_stall", StallM, 0);
      tick();
      chk("reclear_noreq", mem_req, 0);
      chk("reclear_rdata", ReadDataM, 0);
      do_access(1, 0, 3'b010, 32'h0000_5000, 32'h0, 32'hCAFE_F00D, 2);

      // Random mix of loads, stores, illegal and misaligned accesses with idle gaps.
      for (int i = 0; i < 40; i++) begin
         bit rd, wr;
         int op;
         op = int'($urandom_range(0, 2));
         rd = (op != 1);
         wr = (op != 0);
         if ($urandom_range(0, 2) == 0) begin
            idle_inputs();
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            #1;
            chk("gap_stall", StallM, 0);
            tick();
            mem_ready = 1'b0;
            chk("gap_noreq", mem_req, 0);
            chk("gap_rdata", ReadDataM, exp_rd);
         end
         do_access(rd, wr, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                   int'($urandom_range(0, 3)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
